// File: rtl/rom_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the shared ROM slave port.
// The arbiter takes the master modport because it masters the slave side; the slave modport is the environment's view.
interface rom_bus_arbiter_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 10
);
    localparam int unsigned SelWidth = DataWidth / 8;

    logic [1:0]             m_cyc;
    logic [1:0]             m_stb;
    logic [1:0]             m_we;
    logic [2*AddrWidth-1:0] m_addr;
    logic [2*DataWidth-1:0] m_data_m;
    logic [2*SelWidth-1:0]  m_sel;
    logic [DataWidth-1:0]   m_data_s;
    logic [1:0]             m_ack;
    logic [1:0]             m_stall;
    logic [1:0]             m_err;

    logic                   s_cyc;
    logic                   s_stb;
    logic                   s_we;
    logic [AddrWidth-1:0]   s_addr;
    logic [DataWidth-1:0]   s_data_m;
    logic [SelWidth-1:0]    s_sel;
    logic [DataWidth-1:0]   s_data_s;
    logic                   s_ack;
    logic                   s_stall;
    logic                   s_err;

    modport master (
        input  m_cyc, m_stb, m_we, m_addr, m_data_m, m_sel,
        output m_data_s, m_ack, m_stall, m_err,
        output s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel,
        input  s_data_s, s_ack, s_stall, s_err
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_addr, m_data_m, m_sel,
        input  m_data_s, m_ack, m_stall, m_err,
        input  s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel,
        output s_data_s, s_ack, s_stall, s_err
    );
endinterface

// File: rtl/rom_bus_arbiter.sv
// Two-master round-robin arbiter for the pipelined ROM bus; the grant is held for the whole
// bus cycle and is never moved while strobes are still awaiting their ack.
module rom_bus_arbiter #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned MaxOutstanding = 4
) (
    input logic clk,
    input logic rst_n,
    rom_bus_arbiter_if.master bus
);
    localparam int unsigned SelWidth = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [CntWidth-1:0]   outstanding_q, outstanding_d;

    logic                  granted;
    logic                  g;
    logic                  full;
    logic                  pending;
    logic                  req_g;
    logic                  req_o;
    logic                  stb_g;
    logic                  inc;
    logic                  dec;

    logic                  s_cyc;
    logic                  s_stb;
    logic                  s_we;
    logic [AddrWidth-1:0]  s_addr;
    logic [DataWidth-1:0]  s_data_m;
    logic [SelWidth-1:0]   s_sel;
    logic [DataWidth-1:0]  m_data_s;
    logic [1:0]            m_ack;
    logic [1:0]            m_err;
    logic [1:0]            m_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        granted = (state_q != StIdle);
        g       = (state_q == StGrant1);
        full    = (outstanding_q == CntWidth'(MaxOutstanding));
        pending = (outstanding_q != '0);
        req_g   = bus.m_cyc[g];
        req_o   = bus.m_cyc[~g];
        stb_g   = bus.m_stb[g];
    end

    // Bus-side outputs: everything idles to zero (stall high) unless a master owns the bus.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_data_m = '0;
        s_sel    = '0;
        m_data_s = '0;
        m_ack    = 2'b00;
        m_err    = 2'b00;
        m_stall  = 2'b11;
        if (granted) begin
            // cyc stays up after the owner drops it until every accepted strobe is answered.
            s_cyc    = req_g | pending;
            s_stb    = req_g & stb_g & ~full;
            s_we     = bus.m_we[g];
            s_addr   = g ? bus.m_addr[2*AddrWidth-1:AddrWidth] : bus.m_addr[AddrWidth-1:0];
            s_data_m = g ? bus.m_data_m[2*DataWidth-1:DataWidth] : bus.m_data_m[DataWidth-1:0];
            s_sel    = g ? bus.m_sel[2*SelWidth-1:SelWidth] : bus.m_sel[SelWidth-1:0];
            m_data_s = bus.s_data_s;
            m_ack[g]   = bus.s_ack & pending;
            m_err[g]   = bus.s_err & pending;
            m_stall[g] = bus.s_stall | full;
        end
    end

    always_comb begin
        inc           = s_stb & ~bus.s_stall;
        dec           = (bus.s_ack | bus.s_err) & pending;
        outstanding_d = outstanding_q;
        if (inc && !dec) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (dec && !inc) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m_cyc == 2'b01 || (bus.m_cyc == 2'b11 && last_grant_q)) begin
                    state_d      = StGrant0;
                    last_grant_d = 1'b0;
                end else if (bus.m_cyc != 2'b00) begin
                    state_d      = StGrant1;
                    last_grant_d = 1'b1;
                end
            end
            StGrant0, StGrant1: begin
                if (!req_g && !pending) begin
                    if (req_o) begin
                        state_d      = g ? StGrant0 : StGrant1;
                        last_grant_d = ~g;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.s_cyc    = s_cyc;
    assign bus.s_stb    = s_stb;
    assign bus.s_we     = s_we;
    assign bus.s_addr   = s_addr;
    assign bus.s_data_m = s_data_m;
    assign bus.s_sel    = s_sel;
    assign bus.m_data_s = m_data_s;
    assign bus.m_ack    = m_ack;
    assign bus.m_err    = m_err;
    assign bus.m_stall  = m_stall;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Randomized bench for rom_bus_arbiter: two random masters and a delayed-ack slave, checked
// every cycle against an ownership/outstanding-count model of the arbitration rules.
module tb_rom_bus_arbiter;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 10;
    localparam int unsigned SW     = DW / 8;
    localparam int unsigned MaxOut = 2;
    localparam int          Cycles = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_bus_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    rom_bus_arbiter #(
        .DataWidth(DW),
        .AddrWidth(AW),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference state: who owns the bus (-1 none), who was granted last, strobes awaiting ack.
    int owner = -1;
    int last  = 1;
    int pend  = 0;
    int slave_q[$];

    bit [1:0]        cyc, stb, we;
    logic [AW-1:0]   addr [2];
    logic [DW-1:0]   wdat [2];
    logic [SW-1:0]   sel  [2];
    bit              s_ack, s_err, s_stall;
    logic [DW-1:0]   s_rdata;

    task automatic drive_masters();
        for (int i = 0; i < 2; i++) begin
            if (!cyc[i]) cyc[i] = ($urandom_range(3) == 0);
            else if ($urandom_range(7) == 0) cyc[i] = 1'b0;
            stb[i]  = cyc[i] && ($urandom_range(9) < 7);
            we[i]   = $urandom_range(1);
            addr[i] = AW'($urandom);
            wdat[i] = $urandom;
            sel[i]  = SW'($urandom);
        end
        bus.m_cyc    = cyc;
        bus.m_stb    = stb;
        bus.m_we     = we;
        bus.m_addr   = {addr[1], addr[0]};
        bus.m_data_m = {wdat[1], wdat[0]};
        bus.m_sel    = {sel[1], sel[0]};
    endtask

    task automatic drive_slave();
        foreach (slave_q[k]) slave_q[k]--;
        s_ack = 1'b0;
        s_err = 1'b0;
        if (slave_q.size() > 0 && slave_q[0] <= 0) begin
            void'(slave_q.pop_front());
            if ($urandom_range(9) == 0) s_err = 1'b1;
            else s_ack = 1'b1;
        end else if (slave_q.size() == 0 && $urandom_range(29) == 0) begin
            s_ack = 1'b1;  // stray ack with nothing outstanding
        end
        s_stall       = ($urandom_range(4) == 0);
        s_rdata       = $urandom;
        bus.s_ack     = s_ack;
        bus.s_err     = s_err;
        bus.s_stall   = s_stall;
        bus.s_data_s  = s_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {61'd0, bus.s_cyc, bus.s_stb, bus.s_we}, 64'd0);
        check_eq({tag, "_addr"}, 64'(bus.s_addr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(bus.s_data_m), 64'd0);
        check_eq({tag, "_sel"}, 64'(bus.s_sel), 64'd0);
        check_eq({tag, "_rdata"}, 64'(bus.m_data_s), 64'd0);
        check_eq({tag, "_ack_err"}, {60'd0, bus.m_ack, bus.m_err}, 64'd0);
        check_eq({tag, "_stall"}, 64'(bus.m_stall), 64'd3);
    endtask

    initial begin
        bit        gr;
        int        g;
        bit        e_cyc, e_stb, e_we, accept, retire;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdat;
        logic [SW-1:0] e_sel;
        logic [1:0]    e_ack, e_err, e_stall;
        bit        want_reset;
        int        reset_wait;

        cyc = '0; stb = '0; we = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdat[i] = '0; sel[i] = '0;
        end
        bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
        bus.m_addr = '0; bus.m_data_m = '0; bus.m_sel = '0;
        // Slave activity during reset must not leak through.
        bus.s_ack = 1'b1; bus.s_err = 1'b0; bus.s_stall = 1'b0; bus.s_data_s = 32'hdead_beef;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        want_reset = 1'b0;
        reset_wait = 0;

        for (int n = 0; n < Cycles; n++) begin
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            drive_masters();
            drive_slave();
            if (n % 400 == 399) want_reset = 1'b1;

            if (want_reset && (pend > 0 || reset_wait > 40)) begin
                want_reset = 1'b0;
                reset_wait = 0;
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                owner = -1;
                last  = 1;
                pend  = 0;
                continue;
            end
            if (want_reset) reset_wait++;

            #4;
            gr = (owner >= 0);
            g  = gr ? owner : 0;
            e_cyc   = gr && (cyc[g] || pend > 0);
            e_stb   = gr && cyc[g] && stb[g] && (pend < MaxOut);
            e_we    = gr ? we[g] : 1'b0;
            e_addr  = gr ? addr[g] : '0;
            e_wdat  = gr ? wdat[g] : '0;
            e_sel   = gr ? sel[g] : '0;
            e_ack   = 2'b00;
            e_err   = 2'b00;
            e_stall = 2'b11;
            if (gr) begin
                e_stall[g] = s_stall || (pend == MaxOut);
                e_ack[g]   = s_ack && (pend > 0);
                e_err[g]   = s_err && (pend > 0);
            end

            check_eq("ctl", {61'd0, bus.s_cyc, bus.s_stb, bus.s_we}, {61'd0, e_cyc, e_stb, e_we});
            check_eq("addr", 64'(bus.s_addr), 64'(e_addr));
            check_eq("wdata", 64'(bus.s_data_m), 64'(e_wdat));
            check_eq("sel", 64'(bus.s_sel), 64'(e_sel));
            check_eq("ack", 64'(bus.m_ack), 64'(e_ack));
            check_eq("err", 64'(bus.m_err), 64'(e_err));
            check_eq("stall", 64'(bus.m_stall), 64'(e_stall));
            if ((e_ack | e_err) != 2'b00) check_eq("rdata", 64'(bus.m_data_s), 64'(s_rdata));

            if (gr) begin
                accept = e_stb && !s_stall;
                retire = (s_ack || s_err) && (pend > 0);
                if (accept) slave_q.push_back($urandom_range(4, 1));
                if (!cyc[g] && pend == 0) begin
                    if (cyc[1-g]) begin
                        owner = 1 - g;
                        last  = owner;
                    end else begin
                        owner = -1;
                    end
                end
                pend = pend + int'(accept) - int'(retire);
            end else begin
                if (cyc == 2'b11) owner = (last == 0) ? 1 : 0;
                else if (cyc[0]) owner = 0;
                else if (cyc[1]) owner = 1;
                if (owner >= 0) last = owner;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
